dmem_access_ctrl: RTL and testbench

//  MEM-stage sequencer for data-cache accesses. Issues dmem_read/dmem_write with

---
 rtl/dmem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for data-cache accesses.
// Issues cache read/write requests with byte enables and lane-replicated
// store data, stalls the pipeline until the cache responds, and latches the
// raw read word for writeback. Misaligned accesses are suppressed and flagged.
// Optional performance counters are built when DMEM_ACCESS_PERF_EN is defined.
module dmem_access_ctrl #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_read_i,
    input  logic             req_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [width-1:0] addr_i,
    input  logic [width-1:0] wdata_i,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [width-1:0] dmem_address_o,
    output logic [width-1:0] dmem_wdata_o,
    output logic [3:0]       dmem_mbe_o,
    input  logic [width-1:0] dmem_rdata_i,
    input  logic             dmem_resp_i,
    output logic             stall_o,
    output logic [width-1:0] rdata_o,
    output logic             misaligned_o,
    output logic [width-1:0] acc_cnt_o,
    output logic [width-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic             is_read, is_write, req, misaligned;
    logic [3:0]       mbe_comb;
    logic [width-1:0] wdata_comb;
    logic             capture, load_rdata;
    logic             rd_reg, wr_reg;
    logic [width-1:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]       mbe_reg;

    // Request decode, alignment check and byte-enable generation
    always_comb begin
        is_read    = req_read_i;
        is_write   = req_write_i & ~req_read_i;   // read wins when both are set
        req        = req_read_i | req_write_i;
        misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b10:   misaligned = (addr_i[1:0] != 2'b00);
            2'b01:   misaligned = addr_i[0];
            default: misaligned = 1'b0;
        endcase
        mbe_comb = 4'b1111;
        if (is_write) begin
            case (funct3_i[1:0])
                2'b00:   mbe_comb = 4'b0001 << addr_i[1:0];
                2'b01:   mbe_comb = 4'b0011 << addr_i[1:0];
                default: mbe_comb = 4'b1111;
            endcase
        end
    end

    // Store data replicated onto every byte lane it may land in
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_comb[gi*8 +: 8] =
            (funct3_i[1:0] == 2'b00) ? wdata_i[7:0] :
            (funct3_i[1:0] == 2'b01) ? wdata_i[(gi%2)*8 +: 8] :
                                       wdata_i[gi*8 +: 8];
    end

    // Next-state and output decode; issue-cycle outputs come straight from
    // the inputs, BUSY outputs from the request captured at issue
    always_comb begin
        state_next     = state_reg;
        dmem_read_o    = 1'b0;
        dmem_write_o   = 1'b0;
        dmem_address_o = '0;
        dmem_wdata_o   = '0;
        dmem_mbe_o     = 4'b0000;
        stall_o        = 1'b0;
        misaligned_o   = 1'b0;
        capture        = 1'b0;
        load_rdata     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && !rst) begin
                    if (misaligned) begin
                        misaligned_o = 1'b1;
                    end else begin
                        dmem_read_o    = is_read;
                        dmem_write_o   = is_write;
                        dmem_address_o = {addr_i[width-1:2], 2'b00};
                        dmem_wdata_o   = wdata_comb;
                        dmem_mbe_o     = mbe_comb;
                        stall_o        = 1'b1;
                        capture        = 1'b1;
                        load_rdata     = dmem_resp_i & is_read;
                        state_next     = dmem_resp_i ? DONE : BUSY;
                    end
                end
            end
            BUSY: begin
                dmem_read_o    = rd_reg;
                dmem_write_o   = wr_reg;
                dmem_address_o = addr_reg;
                dmem_wdata_o   = wdata_reg;
                dmem_mbe_o     = mbe_reg;
                stall_o        = 1'b1;
                if (dmem_resp_i) begin
                    load_rdata = rd_reg;
                    state_next = DONE;
                end
            end
            // One free cycle so the pipeline advances past this instruction
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, request capture and read-word latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            mbe_reg   <= 4'b0000;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                rd_reg    <= dmem_read_o;
                wr_reg    <= dmem_write_o;
                addr_reg  <= dmem_address_o;
                wdata_reg <= dmem_wdata_o;
                mbe_reg   <= dmem_mbe_o;
            end
            if (load_rdata) begin
                rdata_reg <= dmem_rdata_i;
            end
        end
    end

    assign rdata_o = rdata_reg;

`ifdef DMEM_ACCESS_PERF_EN
    logic [width-1:0] acc_cnt_reg, stall_cnt_reg;

    // Completed-access and stall-cycle counters; a completion in the issue
    // cycle counts the same as one that passed through BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (state_next == DONE) begin
                acc_cnt_reg <= acc_cnt_reg + 1'b1;
            end
            if (stall_o) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign acc_cnt_o   = acc_cnt_reg;
    assign stall_cnt_o = stall_cnt_reg;
`else
    assign acc_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl. Inputs change 2 time units after
// each rising edge; outputs are checked 1 unit later, well away from edges.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read_i, req_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_read_o, dmem_write_o;
    logic [31:0] dmem_address_o, dmem_wdata_o;
    logic [3:0]  dmem_mbe_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_resp_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic [31:0] acc_cnt_o, stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_address_o(dmem_address_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_mbe_o(dmem_mbe_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_resp_i(dmem_resp_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .misaligned_o(misaligned_o), .acc_cnt_o(acc_cnt_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req_read_i   = 1'b0;
        req_write_i  = 1'b0;
        funct3_i     = 3'b000;
        addr_i       = 32'h0;
        wdata_i      = 32'h0;
        dmem_resp_i  = 1'b0;
        dmem_rdata_i = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick(); tick(); settle();
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_read", {31'b0, dmem_read_o}, 32'd0);
        chk("rst_write", {31'b0, dmem_write_o}, 32'd0);
        chk("rst_addr", dmem_address_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_misal", {31'b0, misaligned_o}, 32'd0);
        $display("txn reset");

        // 1: lw 0x100, resp 3 cycles after issue
        tick(); rst = 1'b0;
        req_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100; settle();
        chk("t1_issue_read", {31'b0, dmem_read_o}, 32'd1);
        chk("t1_issue_stall", {31'b0, stall_o}, 32'd1);
        chk("t1_addr", dmem_address_o, 32'h100);
        chk("t1_mbe", {28'b0, dmem_mbe_o}, 32'hF);
        tick(); settle();
        chk("t1_busy1_stall", {31'b0, stall_o}, 32'd1);
        chk("t1_busy1_read", {31'b0, dmem_read_o}, 32'd1);
        tick(); settle();
        chk("t1_busy2_stall", {31'b0, stall_o}, 32'd1);
        tick(); dmem_resp_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF; settle();
        chk("t1_busy3_stall", {31'b0, stall_o}, 32'd1);
        tick(); idle_inputs(); settle();
        chk("t1_done_stall", {31'b0, stall_o}, 32'd0);
        chk("t1_done_read", {31'b0, dmem_read_o}, 32'd0);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        $display("txn lw addr=00000100 rdata=%h", rdata_o);

        // 2: sb 0x203
        tick(); req_write_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h203;
        wdata_i = 32'h000000A5; settle();
        chk("t2_addr", dmem_address_o, 32'h200);
        chk("t2_mbe", {28'b0, dmem_mbe_o}, 32'h8);
        chk("t2_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        chk("t2_write", {31'b0, dmem_write_o}, 32'd1);
        chk("t2_noread", {31'b0, dmem_read_o}, 32'd0);
        tick(); settle();
        chk("t2_busy_write", {31'b0, dmem_write_o}, 32'd1);
        chk("t2_busy_mbe", {28'b0, dmem_mbe_o}, 32'h8);
        tick(); dmem_resp_i = 1'b1; dmem_rdata_i = 32'h11111111; settle();
        chk("t2_resp_write", {31'b0, dmem_write_o}, 32'd1);
        tick(); idle_inputs(); settle();
        chk("t2_done_write", {31'b0, dmem_write_o}, 32'd0);
        chk("t2_rdata_kept", rdata_o, 32'hDEADBEEF);
        $display("txn sb addr=00000203 wdata=000000a5");

        // 3: sh 0x302, then misaligned lh 0x301 and sw 0x102
        tick(); req_write_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h302;
        wdata_i = 32'h00001234; settle();
        chk("t3_mbe", {28'b0, dmem_mbe_o}, 32'hC);
        chk("t3_wdata", dmem_wdata_o, 32'h12341234);
        chk("t3_addr", dmem_address_o, 32'h300);
        tick(); dmem_resp_i = 1'b1; settle();
        tick(); idle_inputs(); settle();
        chk("t3_done_stall", {31'b0, stall_o}, 32'd0);
        $display("txn sh addr=00000302 wdata=00001234");
        tick(); req_read_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h301; settle();
        chk("t3_lh_misal", {31'b0, misaligned_o}, 32'd1);
        chk("t3_lh_noread", {31'b0, dmem_read_o}, 32'd0);
        chk("t3_lh_nostall", {31'b0, stall_o}, 32'd0);
        $display("txn lh addr=00000301 misaligned");
        tick(); idle_inputs(); req_write_i = 1'b1; funct3_i = 3'b010;
        addr_i = 32'h102; settle();
        chk("t3_sw_misal", {31'b0, misaligned_o}, 32'd1);
        chk("t3_sw_nowrite", {31'b0, dmem_write_o}, 32'd0);
        $display("txn sw addr=00000102 misaligned");
        tick(); idle_inputs(); settle();
        chk("t3_misal_clear", {31'b0, misaligned_o}, 32'd0);
        chk("t3_rdata_kept", rdata_o, 32'hDEADBEEF);

        // 4: lw 0x40 with response in the issue cycle
        tick(); req_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D; settle();
        chk("t4_issue_stall", {31'b0, stall_o}, 32'd1);
        chk("t4_issue_read", {31'b0, dmem_read_o}, 32'd1);
        tick(); idle_inputs(); settle();
        chk("t4_done_stall", {31'b0, stall_o}, 32'd0);
        chk("t4_rdata", rdata_o, 32'hCAFEF00D);
        $display("txn lw addr=00000040 rdata=%h same-cycle resp", rdata_o);

        // sb at byte 1: single-lane enable
        tick(); req_write_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h001;
        wdata_i = 32'h0000003C; dmem_resp_i = 1'b1; settle();
        chk("sb1_mbe", {28'b0, dmem_mbe_o}, 32'h2);
        chk("sb1_wdata", dmem_wdata_o, 32'h3C3C3C3C);
        tick(); idle_inputs(); settle();
        $display("txn sb addr=00000001 wdata=0000003c");

        // 5: reset while BUSY, late response ignored
        tick(); req_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h80; settle();
        tick(); settle();
        chk("t5_busy_stall", {31'b0, stall_o}, 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; idle_inputs(); settle();
        chk("t5_rst_stall", {31'b0, stall_o}, 32'd0);
        chk("t5_rst_read", {31'b0, dmem_read_o}, 32'd0);
        chk("t5_rst_rdata", rdata_o, 32'h0);
        tick(); dmem_resp_i = 1'b1; dmem_rdata_i = 32'h55555555; settle();
        chk("t5_late_stall", {31'b0, stall_o}, 32'd0);
        chk("t5_late_read", {31'b0, dmem_read_o}, 32'd0);
        tick(); idle_inputs(); settle();
        chk("t5_late_rdata", rdata_o, 32'h0);
        chk("t5_late_stall2", {31'b0, stall_o}, 32'd0);
        $display("txn reset-in-busy rdata=%h", rdata_o);

        // 6: two accesses with 2-cycle response, then counters
        for (int n = 0; n < 2; n++) begin
            tick(); req_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h10 + n * 4; settle();
            tick(); settle();
            tick(); dmem_resp_i = 1'b1; dmem_rdata_i = 32'hA0 + n; settle();
            tick(); idle_inputs(); settle();
            chk("t6_rdata", rdata_o, 32'hA0 + n);
            $display("txn lw addr=%h rdata=%h", 32'h10 + n * 4, rdata_o);
        end
`ifdef DMEM_ACCESS_PERF_EN
        chk("t6_acc_cnt", acc_cnt_o, 32'd2);
        chk("t6_stall_cnt", stall_cnt_o, 32'd6);
`else
        chk("t6_acc_cnt", acc_cnt_o, 32'd0);
        chk("t6_stall_cnt", stall_cnt_o, 32'd0);
`endif
        $display("txn counters acc=%0d stall=%0d", acc_cnt_o, stall_cnt_o);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
